// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 9-bit CPU.
// Owns the PC, fetches instructions from instruction memory and decodes each one into
// registered datapath controls. It stalls on data memory and multi-cycle ops, resolves
// jumps and branches, and handles the start/done handshake.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   start_i            one-cycle pulse, starts execution at PC 0 (from IDLE or DONE only)
//   instr_i            instruction word at address pc_o, qualified by instr_valid_i
//   zero_i             datapath zero flag, sampled in EXEC
//   tgt_addr_i         jump/branch target
//   mem_ready_i        data memory access complete
//   pc_o               instruction address
//   op_o, op_valid_o   decoded operation and its qualifier
//   reg_src_o/reg_dst_o/imm_o/mem_sel_o/alu_rs_o  decoded fields (unused fields are 0)
//   busy_o, done_o     running / halted status
module control_sequencer #(
  parameter int unsigned IW        = 9,
  parameter int unsigned RW        = 4,
  parameter int unsigned PCW       = 10,
  parameter int unsigned MULTI_CYC = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [IW-1:0]  instr_i,
  input  logic           instr_valid_i,
  input  logic           zero_i,
  input  logic [PCW-1:0] tgt_addr_i,
  input  logic           mem_ready_i,
  output logic [PCW-1:0] pc_o,
  output logic [4:0]     op_o,
  output logic           op_valid_o,
  output logic [RW-1:0]  reg_src_o,
  output logic [RW-1:0]  reg_dst_o,
  output logic [RW-1:0]  imm_o,
  output logic           mem_sel_o,
  output logic           alu_rs_o,
  output logic           busy_o,
  output logic           done_o
);

  // Counter only needs to hold MULTI_CYC-1.
  localparam int unsigned CntW = (MULTI_CYC > 1) ? $clog2(MULTI_CYC) : 1;

  typedef enum logic [4:0] {
    OpNop   = 5'd0,
    OpLoad  = 5'd1,
    OpStor  = 5'd2,
    OpIncr  = 5'd3,
    OpDecr  = 5'd4,
    OpJizr  = 5'd5,
    OpJnzr  = 5'd6,
    OpBizr  = 5'd7,
    OpBnzr  = 5'd8,
    OpSeth  = 5'd9,
    OpAlu   = 5'd10,
    OpLslc  = 5'd11,
    OpLsrc  = 5'd12,
    OpFlip  = 5'd13,
    OpFunc  = 5'd14,
    OpLithi = 5'd15,
    OpLitlo = 5'd16,
    OpMov   = 5'd17
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWaitMem,
    StMulti,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  op_e             op_q, op_d;
  logic [RW-1:0]   src_q, src_d;
  logic [RW-1:0]   dst_q, dst_d;
  logic [RW-1:0]   imm_q, imm_d;
  logic            mem_sel_q, mem_sel_d;
  logic            alu_rs_q, alu_rs_d;
  logic            halt_q, halt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Decoded view of instr_i
  logic [1:0]    grp, sub;
  logic          bit_sel;
  logic [RW-1:0] operand;
  op_e           dec_op;
  logic [RW-1:0] dec_src, dec_dst;
  logic          dec_mem_sel, dec_alu_rs, dec_halt;

  assign grp     = instr_i[IW-1 -: 2];
  assign sub     = instr_i[IW-3 -: 2];
  assign bit_sel = instr_i[IW-5];
  assign operand = instr_i[RW-1:0];

  always_comb begin
    dec_op      = OpNop;
    dec_src     = '0;
    dec_dst     = '0;
    dec_mem_sel = 1'b0;
    dec_alu_rs  = 1'b0;
    dec_halt    = 1'b0;
    unique case (grp)
      2'b10: begin
        unique case (sub)
          2'b00: begin
            dec_op      = bit_sel ? OpStor : OpLoad;
            dec_mem_sel = operand[RW-1];
            if (bit_sel) dec_src = {1'b0, operand[RW-2:0]};
            else         dec_dst = {1'b0, operand[RW-2:0]};
          end
          2'b01: begin
            dec_op  = bit_sel ? OpDecr : OpIncr;
            dec_dst = operand;
          end
          2'b10: dec_op = bit_sel ? OpJnzr : OpJizr;
          default: begin
            dec_op  = bit_sel ? OpBnzr : OpBizr;
            dec_src = operand;
          end
        endcase
      end
      2'b11: begin
        unique case (sub)
          2'b00: dec_op = OpSeth;
          2'b01: begin
            dec_op     = OpAlu;
            dec_alu_rs = bit_sel;
          end
          2'b10: dec_op = bit_sel ? OpLsrc : OpLslc;
          default: begin
            if (!bit_sel) begin
              dec_op = OpFlip;
            end else if (&operand) begin
              dec_halt = 1'b1;  // HALT presents as NOP
            end else begin
              dec_op = OpFunc;
            end
          end
        endcase
      end
      default: begin
        if (sub == 2'b00) begin
          dec_op = bit_sel ? OpLithi : OpLitlo;
        end else begin
          dec_op  = OpMov;
          dec_dst = instr_i[IW-2 -: RW];
          dec_src = operand;
        end
      end
    endcase
  end

  logic           take_branch;
  logic [PCW-1:0] pc_inc;

  assign pc_inc      = pc_q + PCW'(1);
  assign take_branch = (((op_q == OpJizr) || (op_q == OpBizr)) && zero_i) ||
                       (((op_q == OpJnzr) || (op_q == OpBnzr)) && !zero_i);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    mem_sel_d = mem_sel_q;
    alu_rs_d  = alu_rs_q;
    halt_d    = halt_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        if (instr_valid_i) begin
          op_d      = dec_op;
          src_d     = dec_src;
          dst_d     = dec_dst;
          imm_d     = operand;
          mem_sel_d = dec_mem_sel;
          alu_rs_d  = dec_alu_rs;
          halt_d    = dec_halt;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (halt_q) begin
          state_d = StDone;
        end else begin
          case (op_q)
            OpLoad, OpStor: begin
              // Memory may already be ready in the EXEC cycle itself.
              if (mem_ready_i) begin
                pc_d    = pc_inc;
                state_d = StFetch;
              end else begin
                state_d = StWaitMem;
              end
            end
            OpLslc, OpLsrc, OpFunc: begin
              if (MULTI_CYC > 1) begin
                cnt_d   = CntW'(MULTI_CYC - 1);
                state_d = StMulti;
              end else begin
                pc_d    = pc_inc;
                state_d = StFetch;
              end
            end
            default: begin
              pc_d    = take_branch ? tgt_addr_i : pc_inc;
              state_d = StFetch;
            end
          endcase
        end
      end
      StWaitMem: begin
        if (mem_ready_i) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StMulti: begin
        // EXEC already counted as the first cycle; leave when the count hits zero.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      op_q      <= OpNop;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      mem_sel_q <= 1'b0;
      alu_rs_q  <= 1'b0;
      halt_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      mem_sel_q <= mem_sel_d;
      alu_rs_q  <= alu_rs_d;
      halt_q    <= halt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_o       = pc_q;
  assign op_o       = op_q;
  assign reg_src_o  = src_q;
  assign reg_dst_o  = dst_q;
  assign imm_o      = imm_q;
  assign mem_sel_o  = mem_sel_q;
  assign alu_rs_o   = alu_rs_q;
  assign op_valid_o = (state_q == StExec) || (state_q == StWaitMem) || (state_q == StMulti);
  assign busy_o     = op_valid_o || (state_q == StFetch);
  assign done_o     = (state_q == StDone);

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised, multi-cycle successor to the combinational instruction decoder of the 9-bit CPU.
- Owns the PC and fetches instructions from instruction memory.
- Decodes each instruction into registered datapath controls, stalls on memory and multi-cycle ops, resolves jumps and branches, and drives the start/done handshake with the testbench.
- Sits between instruction memory and the register file / ALU / data memory.

Parameters:
- IW, 9: instruction width. Opcode fields are anchored at the MSB; the operand field is instr[IW-6:0].
- RW, 4: register index / operand width. Must equal IW-5.
- PCW, 10: program counter width.
- MULTI_CYC, 2: cycles op_valid is held for LSLC, LSRC and FUNC (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins execution at PC 0.
- instr  in  IW  instruction word for address pc.
- instr_valid  in  1  instr is valid this cycle.
- zero  in  1  datapath zero flag, sampled in EXEC.
- tgt_addr  in  PCW  jump/branch target from datapath LUT/register.
- mem_ready  in  1  data memory has completed the access.
- pc  out  PCW  instruction address.
- op  out  5  operation code: NOP0 LOAD1 STOR2 INCR3 DECR4 JIZR5 JNZR6 BIZR7 BNZR8 SETH9 ALU10 LSLC11 LSRC12 FLIP13 FUNC14 LITHI15 LITLO16 MOV17.
- op_valid  out  1  op and fields are valid.
- reg_src  out  RW  source register.
- reg_dst  out  RW  destination register.
- imm  out  RW  raw operand field.
- mem_sel  out  1  data memory bank select.
- alu_rs  out  1  ALU result select.
- busy  out  1  sequencer is running.
- done  out  1  program halted.

Behaviour:
- Reset: state IDLE; pc=0; op=NOP; all fields=0; op_valid=0; busy=0; done=0. Reset overrides every state, including mid-stall. Unused fields drive 0, never z.

States:
- IDLE: busy=0. start → FETCH, pc=0.
- FETCH: busy=1. If instr_valid, latch instr and decode into output registers, then go to EXEC. Otherwise stay.
- EXEC: op_valid=1 for exactly one cycle.
  - LOAD/STOR go to WAIT_MEM.
  - LSLC/LSRC/FUNC go to MULTI with a counter loaded to MULTI_CYC-1. If MULTI_CYC=1, treat as single-cycle.
  - HALT encoding goes to DONE.
  - All other ops update pc and go to FETCH.
- WAIT_MEM: op_valid held high with fields stable. When mem_ready=1 (including in the EXEC cycle itself), pc+1 and go to FETCH.
- MULTI: op_valid held. Decrement the counter; at 0, pc+1 and go to FETCH.
- DONE: done=1, busy=0, op_valid=0. Holds until start, which restarts at pc=0 and clears done.
- start in any state other than IDLE or DONE is ignored.

Decode (default IW=9; top fields relative to MSB):
- instr[8:7]=2, [6:5]=0: [4]=0 → LOAD, dst=[2:0]; [4]=1 → STOR, src=[2:0]; mem_sel=[3].
- instr[8:7]=2, [6:5]=1: [4]=0 → INCR, [4]=1 → DECR; dst=[3:0].
- instr[8:7]=2, [6:5]=2: [4]=0 → JIZR, [4]=1 → JNZR.
- instr[8:7]=2, [6:5]=3: [4]=0 → BIZR, [4]=1 → BNZR; src=[3:0].
- instr[8:7]=3, [6:5]=0: SETH.
- instr[8:7]=3, [6:5]=1: ALU; alu_rs=[4]; imm=[3:0] is the math op.
- instr[8:7]=3, [6:5]=2: [4]=0 → LSLC, [4]=1 → LSRC. These are distinct codes.
- instr[8:7]=3, [6:5]=3: [4]=0 → FLIP; [4]=1 → FUNC, except operand all-ones → HALT (op=NOP, go to DONE).
- instr[8:7]∈{0,1}: [6:5]=0 → literal, [4]=1 → LITHI, [4]=0 → LITLO, imm=[3:0]. Otherwise MOV, dst=[7:4], src=[3:0].
- imm always carries [3:0].

Next PC:
- JIZR/BIZR with zero=1, or JNZR/BNZR with zero=0: pc=tgt_addr. Otherwise pc+1.
- pc wraps modulo 2^PCW silently.

Test Plan:
- reset, start, instr=9'b0_0000_0101 with instr_valid=1 → EXEC: op=16 (LITLO), imm=5, op_valid for 1 cycle, pc 0→1.
- instr=9'b0_0110_0010 → op=17 (MOV), reg_dst=6, reg_src=2.
- instr=9'b10_00_0_1_011 with mem_ready low for 3 cycles → op=1 (LOAD), mem_sel=1, reg_dst=3, op_valid held 4 cycles, pc increments once.
- instr=9'b10_10_0_0111, zero=1, tgt_addr=10'h05A → pc=10'h05A. Repeat with zero=0 → pc+1. pc=10'h3FF with a non-jump → pc=0.
- MULTI_CYC=3, instr=9'b11_10_1_0000 → op=12 (LSRC, not 11), op_valid for 3 cycles.
- instr=9'b11_11_1_1111 → done=1 held for ≥5 cycles; start → pc=0, done=0. reset asserted during WAIT_MEM → next cycle op_valid=0, busy=0, pc=0.
